window_generator: RTL and testbench
===================================

WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 The block SHALL have parameter KERNEL_SIZE, default 3: window edge K; legal range 2..ROW_SIZE.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-003 The block SHALL have parameter ROW_SIZE, default 5: pixels per image row.
REQ-004 The block SHALL have parameter COL_SIZE, default 5: rows per frame; legal range KERNEL_SIZE..any.
REQ-005 The block SHALL have parameter STRIDE, default 1: window step in both axes; legal range 1..KERNEL_SIZE.
REQ-006 The block SHALL have input clock, 1 bit: single clock; all logic samples on the rising edge.
REQ-007 The block SHALL have input sreset_n, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL have input data_valid, 1 bit: data_in is accepted on every rising edge where data_valid=1.
REQ-009 The block SHALL have input data_in, DATA_WIDTH bits: raster-order pixel.
REQ-010 The block SHALL have output window_out, K*K*DATA_WIDTH bits: current KxK window.
REQ-011 The block SHALL have output window_valid, 1 bit: one-cycle pulse marking window_out as a legal window.
REQ-012 The block SHALL have output frame_done, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 Storage SHALL be a shift chain of (K-1)*ROW_SIZE+K pixel registers; the chain advances only on accepted pixels; with data_valid=0, all state holds.
REQ-014 Column counter col (0..ROW_SIZE-1) and row counter row (0..COL_SIZE-1) SHALL track the position of the pixel being accepted; col wraps to 0 and row increments at col=ROW_SIZE-1; both wrap to 0 after pixel (COL_SIZE-1, ROW_SIZE-1).
REQ-015 The state machine SHALL have states FILL (row<K-1) and STREAM (row>=K-1); FILL->STREAM on acceptance of pixel (K-2, ROW_SIZE-1); STREAM->FILL on acceptance of the last pixel of the frame.
REQ-016 A pixel accepted at (row,col) SHALL qualify as a window when row>=K-1, col>=K-1, (row-(K-1)) mod STRIDE=0 and (col-(K-1)) mod STRIDE=0.
REQ-017 window_valid SHALL assert exactly one cycle after the rising edge that accepted a qualifying pixel, for one cycle; latency 1.
REQ-018 Window layout: window_out[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] SHALL hold pixel (row-(K-1)+r, col-(K-1)+c), with r=0 the top (oldest) row and c=0 the leftmost column.
REQ-019 window_out SHALL be a direct tap of the chain; its value is only defined while window_valid=1.
REQ-020 Windows SHALL never straddle a row edge (guaranteed by col>=K-1) and SHALL never mix frames (guaranteed by row>=K-1 after frame wrap).
REQ-021 frame_done SHALL pulse one cycle after the last pixel of a frame is accepted, coincident with that pixel's window_valid when it qualifies.
REQ-022 Back-to-back frames SHALL need no idle cycles; pixel 0 of the next frame may be accepted on the cycle after the last pixel of the previous frame.
REQ-023 Mod-STRIDE checks SHALL use per-axis phase counters, not dividers; with STRIDE=1 they reduce to constants.

Reset
REQ-024 When sreset_n=0 at a rising edge, the block SHALL clear all chain registers to 0, col, row and the phase counters to 0, window_valid and frame_done to 0, and the state to FILL.
REQ-025 Reset SHALL win over a simultaneous data_valid=1; that pixel is discarded.
REQ-026 Reset mid-frame SHALL abandon the frame; the next accepted pixel is (0,0) of a new frame.

Structure
REQ-027 A shared package SHALL hold the parameter defaults, the state encoding (FILL, STREAM) and the window index function (r*K+c).
REQ-028 A single sub-module pixel_shift_reg (DATA_WIDTH register with sreset_n and enable) SHALL be instantiated per chain stage.

Verification
REQ-029 K=3, ROW_SIZE=5, COL_SIZE=5, STRIDE=1; data_in = 0..24 continuously -> first window_valid the cycle after pixel 12, window_out = {0,1,2,5,6,7,10,11,12}; 9 pulses total; last window {12,13,14,17,18,19,22,23,24}, coincident with frame_done.
REQ-030 Same stream with STRIDE=2 -> exactly 4 window_valid pulses, after pixels 12, 14, 22, 24.
REQ-031 data_valid toggles 1/0 every cycle -> same 9 windows in the same order; window_valid never asserts in the cycle after a data_valid=0 cycle.
REQ-032 Two frames back-to-back (values 0..24, then 100..124) -> second frame's first window = {100,101,102,105,106,107,110,111,112}; no window contains pixels of both frames.
REQ-033 sreset_n=0 for one cycle after pixel 17, then restart with 0..24 -> no window_valid before new pixel 12; outputs exactly as in REQ-029.
REQ-034 sreset_n=0 and data_valid=1 on the same edge -> window_valid=0, frame_done=0, and counters at 0 on the next cycle.

Source files
------------

// File: rtl/window_generator_pkg.sv
// Shared defaults, FSM encoding and window index helper for the window generator.
package window_generator_pkg;

   localparam int unsigned DEF_KERNEL_SIZE = 3;
   localparam int unsigned DEF_DATA_WIDTH  = 8;
   localparam int unsigned DEF_ROW_SIZE    = 5;
   localparam int unsigned DEF_COL_SIZE    = 5;
   localparam int unsigned DEF_STRIDE      = 1;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Flat window slot of pixel (r, c), r = 0 top row, c = 0 leftmost column.
   function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned k);
      return r * k + c;
   endfunction

endpackage

// File: rtl/window_generator_pixel_shift_reg.sv
// One pixel stage of the line-buffer shift chain.
module pixel_shift_reg #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  sreset_n,
   input  logic                  i_enable,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [DATA_WIDTH-1:0] r_data;

   // Load the previous stage on every accepted pixel, hold otherwise.
   always_ff @(posedge clock) begin
      if (!sreset_n)     r_data <= '0;
      else if (i_enable) r_data <= i_data;
   end

   assign o_data = r_data;

endmodule

// File: rtl/window_generator.sv
// Sliding KxK window extractor over a raster pixel stream.
module window_generator
   import window_generator_pkg::*;
#(
   parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned ROW_SIZE    = DEF_ROW_SIZE,
   parameter int unsigned COL_SIZE    = DEF_COL_SIZE,
   parameter int unsigned STRIDE      = DEF_STRIDE
) (
   input  logic                                      clock,
   input  logic                                      sreset_n,
   input  logic                                      data_valid,
   input  logic [DATA_WIDTH-1:0]                     data_in,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
   output logic                                      window_valid,
   output logic                                      frame_done
);

   localparam int unsigned K         = KERNEL_SIZE;
   localparam int unsigned CHAIN_LEN = (K - 1) * ROW_SIZE + K;
   localparam int unsigned COL_W     = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam int unsigned ROW_W     = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
   localparam int unsigned PH_W      = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   state_t            r_state, w_state_nxt;
   logic [COL_W-1:0]  r_col, w_col_nxt;
   logic [ROW_W-1:0]  r_row, w_row_nxt;
   logic [PH_W-1:0]   r_col_ph, w_col_ph_nxt;
   logic [PH_W-1:0]   r_row_ph, w_row_ph_nxt;
   logic              w_last_col, w_last_pix, w_col_ok, w_row_ok, w_win_hit;
   logic [DATA_WIDTH-1:0] w_chain [CHAIN_LEN];

   // Shift chain: stage 0 takes the incoming pixel, stage i holds the pixel i steps older.
   for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_chain
      if (i == 0) begin : g_head
         pixel_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clock    (clock),
            .sreset_n (sreset_n),
            .i_enable (data_valid),
            .i_data   (data_in),
            .o_data   (w_chain[i])
         );
      end else begin : g_tail
         pixel_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clock    (clock),
            .sreset_n (sreset_n),
            .i_enable (data_valid),
            .i_data   (w_chain[i-1]),
            .o_data   (w_chain[i])
         );
      end
   end

   // Window taps: pixel (r, c) of the window sits (K-1-r) rows and (K-1-c) pixels back.
   for (genvar r = 0; r < K; r++) begin : g_win_r
      for (genvar c = 0; c < K; c++) begin : g_win_c
         localparam int unsigned IDX = win_idx(r, c, K);
         localparam int unsigned TAP = (K - 1 - r) * ROW_SIZE + (K - 1 - c);
         assign window_out[IDX*DATA_WIDTH +: DATA_WIDTH] = w_chain[TAP];
      end
   end

   // Next-state: position counters, stride phases, FILL/STREAM and window qualification.
   always_comb begin
      w_state_nxt  = r_state;
      w_col_nxt    = r_col;
      w_row_nxt    = r_row;
      w_col_ph_nxt = r_col_ph;
      w_row_ph_nxt = r_row_ph;

      w_last_col = (r_col == COL_W'(ROW_SIZE - 1));
      w_last_pix = w_last_col && (r_row == ROW_W'(COL_SIZE - 1));
      w_col_ok   = (r_col >= COL_W'(K - 1)) && ((STRIDE == 1) || (r_col_ph == '0));
      w_row_ok   = (r_state == STREAM) && ((STRIDE == 1) || (r_row_ph == '0));
      w_win_hit  = data_valid && w_col_ok && w_row_ok;

      if (data_valid) begin
         // Column phase is pinned to 0 until the first window column, then counts mod STRIDE.
         if (w_last_col || (r_col < COL_W'(K - 1)))  w_col_ph_nxt = '0;
         else if (r_col_ph == PH_W'(STRIDE - 1))     w_col_ph_nxt = '0;
         else                                        w_col_ph_nxt = r_col_ph + PH_W'(1);

         if (w_last_col) begin
            w_col_nxt = '0;
            w_row_nxt = w_last_pix ? '0 : r_row + ROW_W'(1);
            if (w_last_pix || (r_row < ROW_W'(K - 1))) w_row_ph_nxt = '0;
            else if (r_row_ph == PH_W'(STRIDE - 1))    w_row_ph_nxt = '0;
            else                                       w_row_ph_nxt = r_row_ph + PH_W'(1);
         end else begin
            w_col_nxt = r_col + COL_W'(1);
         end

         case (r_state)
            FILL:    if (w_last_col && (r_row == ROW_W'(K - 2))) w_state_nxt = STREAM;
            STREAM:  if (w_last_pix) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
         endcase
      end
   end

   // State, counters and registered output pulses.
   always_ff @(posedge clock) begin
      if (!sreset_n) begin
         r_state      <= FILL;
         r_col        <= '0;
         r_row        <= '0;
         r_col_ph     <= '0;
         r_row_ph     <= '0;
         window_valid <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_col        <= w_col_nxt;
         r_row        <= w_row_nxt;
         r_col_ph     <= w_col_ph_nxt;
         r_row_ph     <= w_row_ph_nxt;
         window_valid <= w_win_hit;
         frame_done   <= data_valid && w_last_pix;
      end
   end

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench: STRIDE=1 and STRIDE=2 instances share one stimulus stream.
module tb_window_generator;

   localparam int K  = 3;
   localparam int DW = 8;
   localparam int RS = 5;
   localparam int CS = 5;
   localparam int WW = K * K * DW;

   logic          clock = 1'b0;
   logic          sreset_n = 1'b0;
   logic          data_valid = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [WW-1:0] win0, win1;
   logic          wv0, wv1, fd0, fd1;

   always #5 clock = ~clock;

   window_generator #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .ROW_SIZE(RS), .COL_SIZE(CS), .STRIDE(1)) u_dut_s1 (
      .clock(clock), .sreset_n(sreset_n), .data_valid(data_valid), .data_in(data_in),
      .window_out(win0), .window_valid(wv0), .frame_done(fd0));

   window_generator #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .ROW_SIZE(RS), .COL_SIZE(CS), .STRIDE(2)) u_dut_s2 (
      .clock(clock), .sreset_n(sreset_n), .data_valid(data_valid), .data_in(data_in),
      .window_out(win1), .window_valid(wv1), .frame_done(fd1));

   typedef struct {
      int            cyc;
      bit            wv;
      bit            fd;
      logic [WW-1:0] win;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_wv0 = 0;
   int   n_wv1 = 0;
   int   rst_tag = -1;
   int   m_row = 0;
   int   m_col = 0;
   int   img [CS][RS];

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: a pixel at (row,col) yields a window of the KxK block ending there if it lies on the stride grid.
   function automatic void model_accept(input int val, input int tag);
      exp_t e;
      bit   last, qual;
      img[m_row][m_col] = val;
      last = (m_row == CS - 1) && (m_col == RS - 1);
      for (int s = 1; s <= 2; s++) begin
         qual = (m_row >= K - 1) && (m_col >= K - 1) &&
                ((m_row - (K - 1)) % s == 0) && ((m_col - (K - 1)) % s == 0);
         e.cyc = tag;
         e.wv  = qual;
         e.fd  = last;
         e.win = '0;
         if (qual)
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++)
                  e.win[(r*K+c)*DW +: DW] = DW'(img[m_row-(K-1)+r][m_col-(K-1)+c]);
         if (qual || last) begin
            if (s == 1) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
      if (last) begin
         m_row = 0;
         m_col = 0;
      end else if (m_col == RS - 1) begin
         m_col = 0;
         m_row++;
      end else begin
         m_col++;
      end
   endfunction

   // Pops expected entries for one DUT and compares against what it presents this cycle.
   function automatic void score(input int id, input logic wv, input logic fd, input logic [WW-1:0] win);
      exp_t e;
      int   sz;
      sz = (id == 0) ? q0.size() : q1.size();
      while (sz > 0) begin
         e = (id == 0) ? q0[0] : q1[0];
         if (e.cyc >= cyc) break;
         n_checks++;
         n_fail++;
         $display("FAIL missed_out%0d: nothing seen, expected wv=%0d fd=%0d at cycle %0d", id, e.wv, e.fd, e.cyc);
         if (id == 0) void'(q0.pop_front());
         else         void'(q1.pop_front());
         sz--;
      end
      if (wv === 1'b1 || fd === 1'b1) begin
         if (sz == 0 || e.cyc != cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out%0d: got wv=%0d fd=%0d, expected none (cycle %0d)", id, wv, fd, cyc);
         end else begin
            if (id == 0) void'(q0.pop_front());
            else         void'(q1.pop_front());
            check($sformatf("valid%0d", id), WW'(wv), WW'(e.wv));
            check($sformatf("frame_done%0d", id), WW'(fd), WW'(e.fd));
            if (e.wv) check($sformatf("window%0d", id), win, e.win);
         end
         if (wv === 1'b1) begin
            if (id == 0) n_wv0++;
            else         n_wv1++;
         end
      end
   endfunction

   // Monitor: samples outputs on the falling edge.
   always @(negedge clock) begin
      if (cyc == rst_tag) begin
         check("rst_valid0", WW'(wv0), '0);
         check("rst_done0",  WW'(fd0), '0);
         check("rst_valid1", WW'(wv1), '0);
         check("rst_done1",  WW'(fd1), '0);
      end
      score(0, wv0, fd0, win0);
      score(1, wv1, fd1, win1);
   end

   task automatic drive(input bit v, input int d, input bit rn);
      @(negedge clock);
      data_valid = v;
      data_in    = DW'(d);
      sreset_n   = rn;
      if (!rn) begin
         m_row   = 0;
         m_col   = 0;
         rst_tag = cyc + 1;
      end else if (v) begin
         model_accept(d, cyc + 1);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b1);
   endtask

   initial begin
      drive(1'b0, 0, 1'b0);
      drive(1'b0, 0, 1'b0);
      idle(2);

      // Single frame 0..24, continuous.
      for (int i = 0; i < RS * CS; i++) drive(1'b1, i, 1'b1);
      idle(3);
      check("count_s1", WW'(n_wv0), WW'(9));
      check("count_s2", WW'(n_wv1), WW'(4));

      // Same frame with data_valid toggling every cycle.
      for (int i = 0; i < RS * CS; i++) begin
         drive(1'b1, i, 1'b1);
         drive(1'b0, 8'hAA, 1'b1);
      end
      idle(3);
      check("count_toggle_s1", WW'(n_wv0), WW'(18));

      // Back-to-back frames 0..24 then 100..124.
      for (int i = 0; i < RS * CS; i++) drive(1'b1, i, 1'b1);
      for (int i = 0; i < RS * CS; i++) drive(1'b1, 100 + i, 1'b1);
      idle(3);

      // Abandon a frame after pixel 17 with reset colliding with a valid pixel, then restart.
      for (int i = 0; i <= 17; i++) drive(1'b1, i, 1'b1);
      drive(1'b1, 8'h55, 1'b0);
      for (int i = 0; i < RS * CS; i++) drive(1'b1, i, 1'b1);
      idle(3);

      // Randomized traffic with sparse resets.
      for (int i = 0; i < 600; i++)
         drive(($urandom % 4) != 0, int'($urandom % 256), ($urandom % 150) != 0);
      idle(4);

      check("q0_drained", WW'(q0.size()), '0);
      check("q1_drained", WW'(q1.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
